// File: rtl/shared_mem_banked.sv
// ============================================================================
// shared_mem_banked
// ----------------------------------------------------------------------------
// Multi-bank scratchpad shared by COUNT SIMD processors. Word addresses are
// interleaved across BANKS banks (low address bits select the bank). Each bank
// has its own round-robin arbiter, so processors that hit different banks are
// all served in the same cycle. Every processor has a single valid/ready
// request channel carrying both reads and writes. Reads return one cycle after
// acceptance.
//
// Ports:
//   i_clk        clock
//   i_rstn       asynchronous active-low reset
//   i_req_valid  [COUNT]           per-processor request valid
//   i_req_we     [COUNT]           1 = write, 0 = read
//   i_req_addr   [COUNT][ADDR_W]   word address per processor
//   i_wr_data    [COUNT][BUS_SIZE] write data per processor
//   i_wr_size    [COUNT][3]        log2 of the write byte count
//   o_req_ready  [COUNT]           request accepted this cycle (combinational)
//   o_rd_valid   [COUNT]           read data valid (registered)
//   o_rd_data    [COUNT][BUS_SIZE] read data per processor (holds when idle)
// ============================================================================
module shared_mem_banked #(
    parameter int COUNT    = 4,
    parameter int BANKS    = 4,
    parameter int BUS_SIZE = 128,
    parameter int ADDR_W   = 10
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [COUNT-1:0]                  i_req_valid,
    input  logic [COUNT-1:0]                  i_req_we,
    input  logic [COUNT-1:0][ADDR_W-1:0]      i_req_addr,
    input  logic [COUNT-1:0][BUS_SIZE-1:0]    i_wr_data,
    input  logic [COUNT-1:0][2:0]             i_wr_size,
    output logic [COUNT-1:0]                  o_req_ready,
    output logic [COUNT-1:0]                  o_rd_valid,
    output logic [COUNT-1:0][BUS_SIZE-1:0]    o_rd_data
);

    localparam int BANK_W = $clog2(BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int ROWS   = 1 << ROW_W;
    localparam int BYTES  = BUS_SIZE / 8;
    localparam int PTR_W  = $clog2(COUNT);

    // Per-port address split: low bits pick the bank, the rest pick the row.
    logic [COUNT-1:0][BANK_W-1:0] port_bank;
    logic [COUNT-1:0][ROW_W-1:0]  port_row;

    // Per-bank arbitration state and results.
    logic [BANKS-1:0][PTR_W-1:0]  ptr;
    logic [BANKS-1:0][COUNT-1:0]  cand;
    logic [BANKS-1:0]             bank_hit;
    logic [BANKS-1:0][PTR_W-1:0]  win_idx;
    logic [BANKS-1:0][COUNT-1:0]  grant;

    // Winning request steered to each bank.
    logic [BANKS-1:0][ROW_W-1:0]    bank_row;
    logic [BANKS-1:0]               bank_we;
    logic [BANKS-1:0][BUS_SIZE-1:0] bank_wdata;
    logic [BANKS-1:0][2:0]          bank_size;
    logic [BANKS-1:0][BYTES-1:0]    bank_be;
    logic [BUS_SIZE-1:0]            bank_rdata [BANKS];

    // Address decode and the candidate matrix that every bank arbiter sees.
    always_comb begin
        port_bank = '0;
        port_row  = '0;
        cand      = '0;
        for (int p = 0; p < COUNT; p++) begin
            port_bank[p] = i_req_addr[p][BANK_W-1:0];
            port_row[p]  = i_req_addr[p][ADDR_W-1:BANK_W];
        end
        for (int b = 0; b < BANKS; b++) begin
            for (int p = 0; p < COUNT; p++) begin
                cand[b][p] = i_req_valid[p] && (port_bank[p] == BANK_W'(b));
            end
        end
    end

    // Round-robin search: the first candidate at or after ptr[b], wrapping at
    // COUNT. The index is kept as an int so a non-power-of-two COUNT wraps
    // correctly. Ready never looks at we or data, so a requester can decide
    // what to drive without a combinational loop through ready.
    always_comb begin
        int idx;
        idx      = 0;
        bank_hit = '0;
        win_idx  = '0;
        grant    = '0;
        for (int b = 0; b < BANKS; b++) begin
            for (int k = 0; k < COUNT; k++) begin
                idx = int'(ptr[b]) + k;
                if (idx >= COUNT) begin
                    idx = idx - COUNT;
                end
                if (!bank_hit[b] && cand[b][idx]) begin
                    bank_hit[b] = 1'b1;
                    win_idx[b]  = PTR_W'(idx);
                end
            end
            if (bank_hit[b]) begin
                grant[b][win_idx[b]] = 1'b1;
            end
        end
    end

    // A port is ready when it won whichever bank it addressed.
    always_comb begin
        o_req_ready = '0;
        for (int p = 0; p < COUNT; p++) begin
            for (int b = 0; b < BANKS; b++) begin
                if (grant[b][p]) begin
                    o_req_ready[p] = 1'b1;
                end
            end
        end
    end

    // Steer the winning request onto each bank and build its byte enables.
    // A size of 2^size bytes at or above the word width writes the full word.
    always_comb begin
        int nbytes;
        nbytes     = 0;
        bank_row   = '0;
        bank_we    = '0;
        bank_wdata = '0;
        bank_size  = '0;
        bank_be    = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_row[b]   = port_row[win_idx[b]];
            bank_we[b]    = bank_hit[b] && i_req_we[win_idx[b]];
            bank_wdata[b] = i_wr_data[win_idx[b]];
            bank_size[b]  = i_wr_size[win_idx[b]];
            nbytes        = 1 << int'(bank_size[b]);
            for (int i = 0; i < BYTES; i++) begin
                bank_be[b][i] = (i < nbytes);
            end
        end
    end

    // Storage, one array per bank. Contents are deliberately not reset. A
    // partial write merges the new low bytes into the current row contents, so
    // every write is a single full-word update.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [BUS_SIZE-1:0] mem [ROWS];
        logic [BUS_SIZE-1:0] merged;

        assign bank_rdata[b] = mem[bank_row[b]];

        always_comb begin
            merged = mem[bank_row[b]];
            for (int i = 0; i < BYTES; i++) begin
                if (bank_be[b][i]) begin
                    merged[i*8 +: 8] = bank_wdata[b][i*8 +: 8];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (bank_we[b]) begin
                mem[bank_row[b]] <= merged;
            end
        end
    end

    // Advance each bank pointer past its winner; idle banks keep theirs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_hit[b]) begin
                    if (win_idx[b] == PTR_W'(COUNT - 1)) begin
                        ptr[b] <= '0;
                    end else begin
                        ptr[b] <= win_idx[b] + PTR_W'(1);
                    end
                end
            end
        end
    end

    // Read response: the row is sampled at the accept edge and presented for
    // exactly one cycle. Data holds its last value while valid is low.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_valid <= '0;
            o_rd_data  <= '0;
        end else begin
            for (int p = 0; p < COUNT; p++) begin
                o_rd_valid[p] <= o_req_ready[p] && !i_req_we[p];
                if (o_req_ready[p] && !i_req_we[p]) begin
                    o_rd_data[p] <= bank_rdata[port_bank[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_mem_banked.sv
// ============================================================================
// tb_shared_mem_banked
// ----------------------------------------------------------------------------
// Directed bench for shared_mem_banked. A flat word-addressed memory model
// with per-bank round-robin pointers predicts ready, read valid and read data,
// and is compared against the DUT on every falling clock edge. Directed
// scenarios add literal expectations for key results.
// ============================================================================
module tb_shared_mem_banked;

    localparam int COUNT    = 4;
    localparam int BANKS    = 4;
    localparam int BUS_SIZE = 128;
    localparam int ADDR_W   = 10;
    localparam int WORDS    = 1 << ADDR_W;

    logic                           i_clk;
    logic                           i_rstn;
    logic [COUNT-1:0]               i_req_valid;
    logic [COUNT-1:0]               i_req_we;
    logic [COUNT-1:0][ADDR_W-1:0]   i_req_addr;
    logic [COUNT-1:0][BUS_SIZE-1:0] i_wr_data;
    logic [COUNT-1:0][2:0]          i_wr_size;
    logic [COUNT-1:0]               o_req_ready;
    logic [COUNT-1:0]               o_rd_valid;
    logic [COUNT-1:0][BUS_SIZE-1:0] o_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: flat memory, per-bank pointers, expected read responses.
    logic [BUS_SIZE-1:0] mdl_mem [WORDS];
    int                  mdl_ptr [BANKS];
    logic [COUNT-1:0]    mdl_rdv = '0;
    logic [BUS_SIZE-1:0] mdl_rdd [COUNT];

    shared_mem_banked #(
        .COUNT    (COUNT),
        .BANKS    (BANKS),
        .BUS_SIZE (BUS_SIZE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req_valid (i_req_valid),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_wr_data   (i_wr_data),
        .i_wr_size   (i_wr_size),
        .o_req_ready (o_req_ready),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Shared comparison helper; every check goes through here.
    task automatic checkOutput(input string name, input logic [BUS_SIZE-1:0] act,
                               input logic [BUS_SIZE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int bank_of(input logic [ADDR_W-1:0] a);
        return int'(a) % BANKS;
    endfunction

    // Deterministic fill pattern per word address.
    function automatic logic [BUS_SIZE-1:0] pattern(input int a);
        return {32'(32'hC0DE0000 + a), 32'(32'h5EED0000 ^ (a * 7)), ~32'(a), 32'(a * 13 + 1)};
    endfunction

    // First valid requester of bank b at or after its pointer, or -1.
    function automatic int find_winner(input int b);
        int p;
        for (int k = 0; k < COUNT; k++) begin
            p = (mdl_ptr[b] + k) % COUNT;
            if (i_req_valid[p] && bank_of(i_req_addr[p]) == b) return p;
        end
        return -1;
    endfunction

    function automatic logic [COUNT-1:0] mdl_ready();
        logic [COUNT-1:0] r;
        int w;
        r = '0;
        for (int b = 0; b < BANKS; b++) begin
            w = find_winner(b);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        for (int b = 0; b < BANKS; b++) mdl_ptr[b] = 0;
        for (int p = 0; p < COUNT; p++) mdl_rdd[p] = '0;
        for (int a = 0; a < WORDS; a++) mdl_mem[a] = '0;
    end

    // Model update at each accept edge, reset asynchronously.
    always @(posedge i_clk or negedge i_rstn) begin
        int win [BANKS];
        int p, a, nb;
        logic [BUS_SIZE-1:0] mask;
        logic [COUNT-1:0] nrdv;
        if (!i_rstn) begin
            for (int b = 0; b < BANKS; b++) mdl_ptr[b] = 0;
            mdl_rdv = '0;
            for (int q = 0; q < COUNT; q++) mdl_rdd[q] = '0;
        end else begin
            nrdv = '0;
            for (int b = 0; b < BANKS; b++) win[b] = find_winner(b);
            for (int b = 0; b < BANKS; b++) begin
                if (win[b] >= 0) begin
                    p = win[b];
                    a = int'(i_req_addr[p]);
                    if (i_req_we[p]) begin
                        nb = 1 << int'(i_wr_size[p]);
                        if (nb * 8 >= BUS_SIZE) mask = '1;
                        else mask = (BUS_SIZE'(1) << (8 * nb)) - BUS_SIZE'(1);
                        mdl_mem[a] = (mdl_mem[a] & ~mask) | (i_wr_data[p] & mask);
                    end else begin
                        nrdv[p]    = 1'b1;
                        mdl_rdd[p] = mdl_mem[a];
                    end
                    mdl_ptr[b] = (p + 1) % COUNT;
                end
            end
            mdl_rdv = nrdv;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        checkOutput("cyc_req_ready", BUS_SIZE'(o_req_ready), BUS_SIZE'(mdl_ready()));
        checkOutput("cyc_rd_valid", BUS_SIZE'(o_rd_valid), BUS_SIZE'(mdl_rdv));
        for (int p = 0; p < COUNT; p++) begin
            checkOutput($sformatf("cyc_rd_data%0d", p), o_rd_data[p], mdl_rdd[p]);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic we, input int addr,
                                 input logic [BUS_SIZE-1:0] data, input logic [2:0] size);
        i_req_valid[p] = v;
        i_req_we[p]    = we;
        i_req_addr[p]  = ADDR_W'(addr);
        i_wr_data[p]   = data;
        i_wr_size[p]   = size;
    endtask

    task automatic idleAll();
        for (int p = 0; p < COUNT; p++) applyStimulus(p, 1'b0, 1'b0, 0, '0, 3'd0);
    endtask

    // Reset pulse placed between clock edges.
    task automatic resetPulse();
        #2 i_rstn = 1'b0;
        #2 i_rstn = 1'b1;
    endtask

    initial begin
        logic [BUS_SIZE-1:0] lit;
        logic [COUNT-1:0] seq4 [5];
        logic [COUNT-1:0] seq5 [3];

        seq4[0] = 4'b0001; seq4[1] = 4'b0010; seq4[2] = 4'b0100;
        seq4[3] = 4'b1000; seq4[4] = 4'b0001;
        seq5[0] = 4'b0010; seq5[1] = 4'b1000; seq5[2] = 4'b0010;

        i_rstn = 1'b1;
        idleAll();
        #2 i_rstn = 1'b0;
        #1;
        checkOutput("reset_rd_valid", BUS_SIZE'(o_rd_valid), '0);
        checkOutput("reset_rd_data0", o_rd_data[0], '0);
        @(posedge i_clk);
        @(posedge i_clk);
        #3 i_rstn = 1'b1;
        tick();

        // Fill the whole memory, four distinct banks per cycle.
        for (int r = 0; r < WORDS / COUNT; r++) begin
            for (int p = 0; p < COUNT; p++) applyStimulus(p, 1'b1, 1'b1, r * 4 + p, pattern(r * 4 + p), 3'd7);
            tick();
        end
        idleAll();
        tick();

        // Write then read, no contention.
        lit = 128'h0123456789ABCDEF0123456789ABCDEF;
        applyStimulus(0, 1'b1, 1'b1, 5, lit, 3'd4);
        #1 checkOutput("t1_wr_ready", BUS_SIZE'(o_req_ready), BUS_SIZE'(4'b0001));
        tick();
        applyStimulus(0, 1'b1, 1'b0, 5, '0, 3'd4);
        #1 checkOutput("t1_rd_ready", BUS_SIZE'(o_req_ready), BUS_SIZE'(4'b0001));
        tick();
        idleAll();
        checkOutput("t1_rd_valid", BUS_SIZE'(o_rd_valid), BUS_SIZE'(4'b0001));
        checkOutput("t1_rd_data", o_rd_data[0], lit);
        tick();
        checkOutput("t1_valid_drop", BUS_SIZE'(o_rd_valid), '0);
        checkOutput("t1_data_hold", o_rd_data[0], lit);

        // Partial write of two bytes over an all-ones word.
        applyStimulus(1, 1'b1, 1'b1, 8, '1, 3'd4);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 8, 128'h1111_2222_3333_4444_5555_6666_7777_ABCD, 3'd1);
        tick();
        applyStimulus(1, 1'b1, 1'b0, 8, '0, 3'd0);
        tick();
        idleAll();
        checkOutput("t2_partial", o_rd_data[1], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_ABCD);

        // Parallel banks.
        for (int p = 0; p < COUNT; p++) applyStimulus(p, 1'b1, 1'b0, p, '0, 3'd0);
        #1 checkOutput("t3_all_ready", BUS_SIZE'(o_req_ready), BUS_SIZE'(4'b1111));
        tick();
        idleAll();
        checkOutput("t3_all_valid", BUS_SIZE'(o_rd_valid), BUS_SIZE'(4'b1111));
        for (int p = 0; p < COUNT; p++) checkOutput($sformatf("t3_data%0d", p), o_rd_data[p], pattern(p));

        // Write bank 0 alongside a read from bank 1.
        applyStimulus(0, 1'b1, 1'b1, 0, 128'hDEAD, 3'd7);
        applyStimulus(1, 1'b1, 1'b0, 1, '0, 3'd0);
        #1 checkOutput("t3_wr_rd_ready", BUS_SIZE'(o_req_ready), BUS_SIZE'(4'b0011));
        tick();
        idleAll();
        checkOutput("t3_wr_rd_valid", BUS_SIZE'(o_rd_valid), BUS_SIZE'(4'b0010));

        // Four-way contention on bank 0 from reset.
        resetPulse();
        for (int p = 0; p < COUNT; p++) applyStimulus(p, 1'b1, 1'b0, 4 * (p + 1), '0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput($sformatf("t4_grant%0d", i), BUS_SIZE'(o_req_ready), BUS_SIZE'(seq4[i]));
            tick();
        end
        idleAll();

        // Only P1 and P3 contend on bank 2.
        resetPulse();
        applyStimulus(1, 1'b1, 1'b0, 2, '0, 3'd0);
        applyStimulus(3, 1'b1, 1'b0, 6, '0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput($sformatf("t5_grant%0d", i), BUS_SIZE'(o_req_ready), BUS_SIZE'(seq5[i]));
            tick();
        end
        idleAll();
        tick();

        // Reset while a read response is pending.
        applyStimulus(2, 1'b1, 1'b0, 10, '0, 3'd0);
        tick();
        idleAll();
        checkOutput("t6_pre_valid", BUS_SIZE'(o_rd_valid), BUS_SIZE'(4'b0100));
        #2 i_rstn = 1'b0;
        #1;
        checkOutput("t6_rst_valid", BUS_SIZE'(o_rd_valid), '0);
        checkOutput("t6_rst_data2", o_rd_data[2], '0);
        #2 i_rstn = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 5, '0, 3'd0);
        applyStimulus(3, 1'b1, 1'b0, 9, '0, 3'd0);
        #1 checkOutput("t6_first_grant", BUS_SIZE'(o_req_ready), BUS_SIZE'(4'b0100));
        tick();
        idleAll();
        checkOutput("t6_read_data", o_rd_data[2], lit);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
